mem_stage_dcache: RTL

- Direct-mapped, write-through, no-write-allocate data cache for the 16-bit pipeline's MEM stage.
- Consumes the EX/MEM register's memory request (read/write enable, ALU-result address, store data).
- Produces the `hit` signal that the pipeline registers use as their advance enable.
- Talks to word-addressed main memory over a req/ack handshake and stalls the pipeline (`hit`=0) on read misses and for every write.

---
 rtl/mem_stage_dcache_pkg.sv | 19 +
 rtl/dcache_array.sv | 56 +++++
 rtl/mem_stage_dcache.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mem_stage_dcache_pkg.sv
// Shared types and sizing for the MEM-stage direct-mapped data cache.
package mem_stage_dcache_pkg;

    localparam int unsigned DCACHE_DATA_W     = 16;
    localparam int unsigned DCACHE_INDEX_BITS = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    // Tag is whatever address bits remain above the line index.
    function automatic int unsigned tag_width(input int unsigned data_w,
                                              input int unsigned index_bits);
        return data_w - index_bits;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the direct-mapped cache: one combinational
// lookup port and one synchronous write port (line fill or word update).
module dcache_array
    import mem_stage_dcache_pkg::*;
#(
    parameter int unsigned INDEX_BITS = DCACHE_INDEX_BITS,
    parameter int unsigned DATA_W     = DCACHE_DATA_W,
    localparam int unsigned TAG_W     = tag_width(DATA_W, INDEX_BITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_index,
    input  logic [TAG_W-1:0]      rd_tag,
    output logic                  lookup_hit_c,
    output logic [DATA_W-1:0]     rd_data_c,
    input  logic                  wr_en,
    input  logic                  wr_fill,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [DATA_W-1:0]     wr_data
);

    localparam int unsigned LINES = 2 ** INDEX_BITS;

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES];
    logic              wr_match_c;

    // Lookup for the live request, and tag match for the pending word update
    always_comb begin
        lookup_hit_c = valid[rd_index] && (tag_mem[rd_index] == rd_tag);
        rd_data_c    = data_mem[rd_index];
        wr_match_c   = valid[wr_index] && (tag_mem[wr_index] == wr_tag);
    end

    // Valid bits: cleared on reset, set by a line fill
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en && wr_fill) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag/data storage; a word update only lands on a line already holding that tag
    always_ff @(posedge clk) begin
        if (wr_en && wr_fill) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end else if (wr_en && wr_match_c) begin
            data_mem[wr_index] <= wr_data;
        end
    end

endmodule

// File: rtl/mem_stage_dcache.sv
// MEM-stage data cache: direct-mapped, write-through, no-write-allocate.
// hit doubles as the pipeline advance enable; misses and writes stall.
module mem_stage_dcache
    import mem_stage_dcache_pkg::*;
#(
    parameter int unsigned INDEX_BITS = DCACHE_INDEX_BITS,
    parameter int unsigned DATA_W     = DCACHE_DATA_W,
    localparam int unsigned TAG_W     = tag_width(DATA_W, INDEX_BITS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              hit,
    output logic              mm_req,
    output logic              mm_we,
    output logic [DATA_W-1:0] mm_addr,
    output logic [DATA_W-1:0] mm_wdata,
    input  logic [DATA_W-1:0] mm_rdata,
    input  logic              mm_ack
);

    state_t                state;
    state_t                state_d;
    logic                  mm_req_d;
    logic                  mm_we_d;
    logic [DATA_W-1:0]     mm_addr_d;
    logic [DATA_W-1:0]     mm_wdata_d;

    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_W-1:0]      req_tag;
    logic [INDEX_BITS-1:0] lat_index;
    logic [TAG_W-1:0]      lat_tag;
    logic                  lookup_hit_c;
    logic [DATA_W-1:0]     line_data_c;
    logic                  arr_we_c;
    logic                  arr_fill_c;
    logic [DATA_W-1:0]     arr_data_c;

    // Live request decode, and the request latched into the memory-bus registers
    assign req_index = addr[INDEX_BITS-1:0];
    assign req_tag   = addr[DATA_W-1:INDEX_BITS];
    assign lat_index = mm_addr[INDEX_BITS-1:0];
    assign lat_tag   = mm_addr[DATA_W-1:INDEX_BITS];

    dcache_array #(
        .INDEX_BITS (INDEX_BITS),
        .DATA_W     (DATA_W)
    ) u_array (
        .clk          (clk),
        .rst          (rst),
        .rd_index     (req_index),
        .rd_tag       (req_tag),
        .lookup_hit_c (lookup_hit_c),
        .rd_data_c    (line_data_c),
        .wr_en        (arr_we_c),
        .wr_fill      (arr_fill_c),
        .wr_index     (lat_index),
        .wr_tag       (lat_tag),
        .wr_data      (arr_data_c)
    );

    // State register plus registered memory-bus request
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            mm_req   <= 1'b0;
            mm_we    <= 1'b0;
            mm_addr  <= '0;
            mm_wdata <= '0;
        end else begin
            state    <= state_d;
            mm_req   <= mm_req_d;
            mm_we    <= mm_we_d;
            mm_addr  <= mm_addr_d;
            mm_wdata <= mm_wdata_d;
        end
    end

    // Next state; the request is sampled only in IDLE and latched on the way out
    always_comb begin
        state_d    = state;
        mm_req_d   = mm_req;
        mm_we_d    = mm_we;
        mm_addr_d  = mm_addr;
        mm_wdata_d = mm_wdata;
        case (state)
            ST_IDLE: begin
                if (mem_write) begin
                    state_d    = ST_WRITE;
                    mm_req_d   = 1'b1;
                    mm_we_d    = 1'b1;
                    mm_addr_d  = addr;
                    mm_wdata_d = wdata;
                end else if (mem_read && !lookup_hit_c) begin
                    state_d   = ST_FILL;
                    mm_req_d  = 1'b1;
                    mm_we_d   = 1'b0;
                    mm_addr_d = addr;
                end
            end
            ST_FILL, ST_WRITE: begin
                if (mm_ack) begin
                    state_d  = ST_IDLE;
                    mm_req_d = 1'b0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                mm_req_d = 1'b0;
            end
        endcase
    end

    // Advance enable, load data and array write controls
    always_comb begin
        hit        = 1'b0;
        rdata      = line_data_c;
        arr_we_c   = 1'b0;
        arr_fill_c = 1'b0;
        arr_data_c = mm_wdata;
        case (state)
            ST_IDLE: begin
                hit = !mem_write && !(mem_read && !lookup_hit_c);
            end
            ST_FILL: begin
                arr_we_c   = mm_ack && !rst;
                arr_fill_c = 1'b1;
                arr_data_c = mm_rdata;
            end
            ST_WRITE: begin
                hit      = mm_ack;
                arr_we_c = mm_ack && !rst;
            end
            default: begin
                hit = 1'b0;
            end
        endcase
    end

endmodule
